// File: rtl/mem_chk_pkg.sv
// rtl/mem_chk_pkg.sv - shared state/pattern types and the pattern generator for mem_chk_master
// MEM_CHK_INVERT_PASS_EN adds the WRITE_INV/READ_INV states.
package mem_chk_pkg;

  // Patterns are built at a fixed wide width and truncated by the user.
  localparam int PAT_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
`ifdef MEM_CHK_INVERT_PASS_EN
    WRITE_INV,
    READ_INV,
`endif
    DRAIN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    PAT_ADDR    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_NADDR   = 2'd2,
    PAT_SEED    = 2'd3
  } pat_sel_e;

  function automatic logic [PAT_W-1:0] pattern(input pat_sel_e sel,
                                               input logic [PAT_W-1:0] addr,
                                               input logic [PAT_W-1:0] seed);
    case (sel)
      PAT_ADDR:    return addr;
      PAT_CHECKER: return addr[0] ? {32{2'b01}} : {32{2'b10}};
      PAT_NADDR:   return ~addr;
      default:     return seed + addr;
    endcase
  endfunction

endpackage

// File: rtl/mem_chk_master_if.sv
// rtl/mem_chk_master_if.sv - request/response bundle between the checker and the single-port memory
interface mem_chk_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_din,
    input  mem_dout
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/mem_chk_rd_pipe.sv
// rtl/mem_chk_rd_pipe.sv - read-latency shift pipe with compare, saturating error count and first-error capture
module mem_chk_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  push_valid_i,
  input  logic [ADDR_WIDTH-1:0] push_addr_i,
  input  logic [DATA_WIDTH-1:0] push_exp_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [ADDR_WIDTH+1:0] err_count_o,
  output logic [ADDR_WIDTH+1:0] err_count_d_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
);
  localparam int ERR_W = ADDR_WIDTH + 2;

  logic                  vld_q  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] exp_q  [RD_LATENCY];
  logic [ERR_W-1:0]      err_q, err_d;
  logic [ADDR_WIDTH-1:0] ferr_q, ferr_d;
  logic                  miscompare;

  // The last stage lines up with the cycle mem_dout carries that read's data.
  assign miscompare = vld_q[RD_LATENCY-1] && (rd_data_i != exp_q[RD_LATENCY-1]);

  always_comb begin
    err_d  = err_q;
    ferr_d = ferr_q;
    if (clear_i) begin
      err_d  = '0;
      ferr_d = '0;
    end else if (miscompare) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (err_q == '0) ferr_d = addr_q[RD_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
      err_q  <= '0;
      ferr_q <= '0;
    end else begin
      vld_q[0]  <= push_valid_i;
      addr_q[0] <= push_addr_i;
      exp_q[0]  <= push_exp_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
      err_q  <= err_d;
      ferr_q <= ferr_d;
    end
  end

  assign err_count_o      = err_q;
  assign err_count_d_o    = err_d;
  assign first_err_addr_o = ferr_q;

endmodule

// File: rtl/mem_chk_master.sv
// rtl/mem_chk_master.sv - write/read-back memory test engine driving a single-port memory
// MEM_CHK_INVERT_PASS_EN adds a second pass with the inverted pattern.
module mem_chk_master
  import mem_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] seed,
  mem_chk_master_if.master      mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [2:0]            DRAIN_LAST = 3'(RD_LATENCY - 1);

  state_e                state_q;
  pat_sel_e              sel_q;
  logic [DATA_WIDTH-1:0] seed_q, dat_q;
  logic [ADDR_WIDTH-1:0] addr_q, nxt_addr;
  logic                  en_q, wr_q, busy_q, done_q, pass_q;
  logic [2:0]            drain_q;
  logic                  at_last, clear;
  logic [DATA_WIDTH-1:0] pat_nxt, pat_start;
  logic [ADDR_WIDTH+1:0] err_count_d;

  assign at_last   = (addr_q == LAST_ADDR);
  assign nxt_addr  = at_last ? '0 : addr_q + ADDR_WIDTH'(1);
  assign pat_nxt   = DATA_WIDTH'(pattern(sel_q, PAT_W'(nxt_addr), PAT_W'(seed_q)));
  assign pat_start = DATA_WIDTH'(pattern(pat_sel_e'(pattern_sel), '0, PAT_W'(seed)));
  assign clear     = (state_q == IDLE) && start;

  // dat_q doubles as write data and as the expected value of the read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= PAT_ADDR;
      seed_q  <= '0;
      dat_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      drain_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WRITE;
            sel_q   <= pat_sel_e'(pattern_sel);
            seed_q  <= seed;
            addr_q  <= '0;
            dat_q   <= pat_start;
            en_q    <= 1'b1;
            wr_q    <= 1'b1;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
          end
        end
        WRITE: begin
          addr_q <= nxt_addr;
          dat_q  <= pat_nxt;
          if (at_last) begin
            state_q <= READ;
            wr_q    <= 1'b0;
          end
        end
        READ: begin
          addr_q <= nxt_addr;
          dat_q  <= pat_nxt;
          if (at_last) begin
`ifdef MEM_CHK_INVERT_PASS_EN
            state_q <= WRITE_INV;
            wr_q    <= 1'b1;
            dat_q   <= ~pat_nxt;
`else
            state_q <= DRAIN;
            en_q    <= 1'b0;
            drain_q <= '0;
`endif
          end
        end
`ifdef MEM_CHK_INVERT_PASS_EN
        WRITE_INV: begin
          addr_q <= nxt_addr;
          dat_q  <= ~pat_nxt;
          if (at_last) begin
            state_q <= READ_INV;
            wr_q    <= 1'b0;
          end
        end
        READ_INV: begin
          addr_q <= nxt_addr;
          dat_q  <= ~pat_nxt;
          if (at_last) begin
            state_q <= DRAIN;
            en_q    <= 1'b0;
            drain_q <= '0;
          end
        end
`endif
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_count_d == '0);
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_chk_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk              (clk),
    .rst              (rst),
    .clear_i          (clear),
    .push_valid_i     (en_q & ~wr_q),
    .push_addr_i      (addr_q),
    .push_exp_i       (dat_q),
    .rd_data_i        (mem.mem_dout),
    .err_count_o      (err_count),
    .err_count_d_o    (err_count_d),
    .first_err_addr_o (first_err_addr)
  );

  assign mem.mem_en   = en_q;
  assign mem.mem_wr   = wr_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_din  = dat_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_mem_chk_master.sv
// tb/tb_mem_chk_master.sv - vector table plus access scoreboard for mem_chk_master
`timescale 1ns/1ps
module tb_mem_chk_master;
  localparam int DW = 32, AW = 4, DEPTH = 16, RD_LAT = 1;
`ifdef MEM_CHK_INVERT_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int EXP_DONE = 1 + 2 * PASSES * DEPTH + RD_LAT;
  localparam int BUDGET   = EXP_DONE + 20;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, pass;
  logic [1:0]    pattern_sel;
  logic [DW-1:0] seed;
  logic [AW+1:0] err_count;
  logic [AW-1:0] first_err_addr;

  mem_chk_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_if ();

  mem_chk_master #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pattern_sel    (pattern_sel),
    .seed           (seed),
    .mem            (mem_if),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  // Memory model with an optional stuck-at-0 fault (stuck_addr < 0 hits every address)
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdp [RD_LAT];
  int            stuck_addr = 0;
  logic [DW-1:0] stuck_mask = '0;

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    logic [DW-1:0] m;
    m = (stuck_addr < 0 || int'(a) == stuck_addr) ? stuck_mask : '0;
    return mem[a] & ~m;
  endfunction

  always @(posedge clk) begin
    if (mem_if.mem_en && mem_if.mem_wr) mem[mem_if.mem_addr] <= mem_if.mem_din;
    rdp[0] <= (mem_if.mem_en && !mem_if.mem_wr) ? rd_val(mem_if.mem_addr) : rdp[0];
    for (int i = 1; i < RD_LAT; i++) rdp[i] <= rdp[i-1];
  end
  assign mem_if.mem_dout = rdp[RD_LAT-1];

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } acc_t;

  typedef struct {
    int            sel;
    logic [DW-1:0] sd;
    int            s_addr;
    logic [DW-1:0] s_mask;
    bit            e_pass;
    int            e_err;
    int            e_ferr;
  } vec_t;

  acc_t exp_q[$];
  vec_t vecs[6];
  int   checks = 0, errors = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] model_pat(input int sel, input int a, input logic [DW-1:0] sd);
    case (sel)
      0:       return DW'(a);
      1:       return (a % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
      2:       return ~DW'(a);
      default: return sd + DW'(a);
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    acc_t got, e;
    if (done === 1'b1) done_cnt++;
    if (mem_if.mem_en === 1'b1) begin
      got.wr   = mem_if.mem_wr;
      got.addr = mem_if.mem_addr;
      got.din  = mem_if.mem_wr ? mem_if.mem_din : '0;
      if (exp_q.size() == 0) begin
        chk("access_unexpected", 64'(got), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("access", 64'(got), 64'(e));
      end
    end
  end

  task automatic run_test(input vec_t v, input bit repulse, input int rst_at);
    acc_t          e;
    logic [DW-1:0] inv;
    int            n, dc0;
    bit            got;
    stuck_addr = v.s_addr;
    stuck_mask = v.s_mask;
    exp_q.delete();
    for (int p = 0; p < PASSES; p++) begin
      inv = (p != 0) ? '1 : '0;
      for (int a = 0; a < DEPTH; a++) begin
        e.wr = 1'b1; e.addr = AW'(a); e.din = model_pat(v.sel, a, v.sd) ^ inv;
        exp_q.push_back(e);
      end
      for (int a = 0; a < DEPTH; a++) begin
        e.wr = 1'b0; e.addr = AW'(a); e.din = '0;
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    pattern_sel = 2'(v.sel);
    seed        = v.sd;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    pattern_sel = 2'($urandom);
    seed        = $urandom;
    dc0         = done_cnt;
    n   = 1;
    got = 1'b0;
    while (!got && n <= BUDGET) begin
      @(negedge clk);
      if (n == 1) begin
        chk("busy_on_start", busy, 1);
        chk("pass_cleared", pass, 0);
        chk("err_cleared", err_count, 0);
      end
      if (rst_at != 0 && n == rst_at) rst = 1'b1;
      if (rst_at != 0 && n == rst_at + 1) begin
        chk("rst_mem_en", mem_if.mem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        exp_q.delete();
        break;
      end
      start = repulse && (n == 10 || n == EXP_DONE - 1 || n == EXP_DONE);
      if (done === 1'b1) got = 1'b1;
      else n++;
    end
    if (rst_at != 0) begin
      repeat (BUDGET) @(negedge clk);
      chk("rst_no_done", done_cnt - dc0, 0);
      chk("rst_idle", mem_if.mem_en, 0);
    end else begin
      chk("done_cycle", got ? n : 0, EXP_DONE);
      chk("pass", pass, v.e_pass);
      chk("err_count", err_count, v.e_err);
      chk("first_err_addr", first_err_addr, v.e_ferr);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_done", busy, 0);
      chk("done_pulse_width", done, 0);
      chk("pass_held", pass, v.e_pass);
      repeat (3) @(negedge clk);
      chk("done_count", done_cnt - dc0, 1);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("idle_no_access", mem_if.mem_en, 0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    pattern_sel = '0;
    seed        = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < RD_LAT; i++) rdp[i] = '0;

    //          sel  seed          s_addr  s_mask        pass  err  ferr
    vecs[0] = '{0,   32'h0,        0,      32'h0,        1'b1, 0,   0};
    vecs[1] = '{1,   32'h0,        5,      32'h1,        1'b0, 1,   5};
    vecs[2] = '{3,   32'hFFFF_FFFE, 0,     32'h0,        1'b1, 0,   0};
    vecs[3] = '{2,   32'h0,        -1,     32'h8000_0000, 1'b0, 16, 0};
    vecs[4] = '{0,   32'h0,        9,      32'h8,        1'b0, 1,   9};
    vecs[5] = '{3,   32'h1234_5678, 3,     32'h1,        1'b0, 1,   3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_en", mem_if.mem_en, 0);
    chk("reset_mem_wr", mem_if.mem_wr, 0);
    chk("reset_mem_addr", mem_if.mem_addr, 0);
    chk("reset_mem_din", mem_if.mem_din, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_err_count", err_count, 0);
    chk("reset_first_err_addr", first_err_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_test(vecs[i], 1'b0, 0);
    run_test(vecs[0], 1'b1, 0);
    run_test(vecs[3], 1'b0, 20);
    run_test(vecs[0], 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
